sprite_collision_mixer: RTL

- Parametrised successor to the hand-written per-frame collision logic and sprite colour priority chain in the top level.
- Takes drawing flags and pixels from N sprite layers each pixel clock and outputs the registered priority-mixed pixel.
- Accumulates cross-group overlaps (e.g. ship/bullets vs asteroids) over the visible frame and latches per-layer hit vectors at each frame pulse.
- Maintains a saturating score counter driven by the hit vectors; feeds asteroid/bullet resets, LEDs and the 7-seg score.

---
 rtl/sprite_pkg.sv | 27 ++
 rtl/layer_priority_mux.sv | 24 ++
 rtl/sprite_collision_mixer.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/sprite_pkg.sv
// Shared types and helpers for the sprite mixing / collision blocks.
package sprite_pkg;

  localparam int COLR_BITS = 12;
  typedef logic [COLR_BITS-1:0] colr_t;
  localparam colr_t BG_COLR = 12'hFFF;

  localparam int MAX_LAYERS = 64;
  localparam int IDX_BITS   = $clog2(MAX_LAYERS);
  localparam int CNT_BITS   = IDX_BITS + 1;
  typedef logic [IDX_BITS-1:0] layer_idx_t;

  typedef enum logic {
    ARM   = 1'b0,
    ACCUM = 1'b1
  } fsm_t;

  function automatic logic [CNT_BITS-1:0] popcount(input logic [MAX_LAYERS-1:0] v);
    logic [CNT_BITS-1:0] n;
    n = '0;
    for (int i = 0; i < MAX_LAYERS; i++) begin
      n = n + CNT_BITS'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/layer_priority_mux.sv
// Combinational lowest-index-first colour select over a stack of sprite layers.
module layer_priority_mux #(
  parameter int LAYERS    = 12,
  parameter int COLR_BITS = 12
) (
  input  logic [LAYERS-1:0]           drawing,
  input  logic [LAYERS*COLR_BITS-1:0] pixels,
  output logic [COLR_BITS-1:0]        colr,
  output logic                        any_draw
);

  // Walk from the lowest priority upwards so the lowest drawing index wins.
  always_comb begin
    colr = '0;
    for (int k = LAYERS - 1; k >= 0; k--) begin
      if (drawing[k]) begin
        colr = pixels[k*COLR_BITS +: COLR_BITS];
      end
    end
  end

  assign any_draw = |drawing;

endmodule

// File: rtl/sprite_collision_mixer.sv
// Priority pixel mixer with per-frame cross-group collision capture and score.
// Optional overlap highlight colour enabled by defining SPRITE_MIX_HIGHLIGHT_EN.
//
// state | meaning
// ARM   | after reset, waiting for the first frame pulse to load group masks
// ACCUM | accumulating cross-group overlaps; frame pulse latches hit_vec
module sprite_collision_mixer import sprite_pkg::*; #(
  parameter int                   LAYERS         = 12,
  parameter int                   COLR_BITS      = 12,
  parameter logic [COLR_BITS-1:0] BG_COLR        = 12'hFFF,
  parameter int                   SCORE_W        = 10,
  parameter logic [COLR_BITS-1:0] HIGHLIGHT_COLR = 12'hF00
) (
  input  logic                        clk_pix,
  input  logic                        reset_n,
  input  logic                        frame,
  input  logic                        de,
  input  logic [LAYERS-1:0]           layer_drawing,
  input  logic [LAYERS*COLR_BITS-1:0] layer_pixels,
  input  logic [LAYERS-1:0]           group_a,
  input  logic [LAYERS-1:0]           group_b,
  input  logic                        score_clr,
  output logic [COLR_BITS-1:0]        pix_out,
  output logic                        de_out,
  output logic [LAYERS-1:0]           hit_vec,
  output logic                        any_hit,
  output logic                        hit_valid,
  output logic [SCORE_W-1:0]          score
);

`ifdef SPRITE_MIX_HIGHLIGHT_EN
  localparam bit HL_EN = 1'b1;
`else
  localparam bit HL_EN = 1'b0;
`endif

  localparam int SUM_W = ((SCORE_W > CNT_BITS) ? SCORE_W : CNT_BITS) + 1;
  localparam logic [SUM_W-1:0] SCORE_MAX = SUM_W'((64'd1 << SCORE_W) - 64'd1);

  fsm_t state, state_nxt;

  logic [LAYERS-1:0]    shadow_a, shadow_b, shadow_b_prev, acc;
  logic [LAYERS-1:0]    vis_draw, b_hits;
  logic                 ov_a, ov_b;
  logic                 load_masks, latch_hits, accumulate;
  logic [COLR_BITS-1:0] mux_colr, pix_nxt;
  logic                 mux_any;
  logic [CNT_BITS-1:0]  b_cnt;
  logic [SUM_W-1:0]     score_base, score_sum;
  logic [SCORE_W-1:0]   score_nxt;

  assign vis_draw = layer_drawing & {LAYERS{de}};
  assign ov_a     = |(vis_draw & shadow_a);
  assign ov_b     = |(vis_draw & shadow_b);

  always_ff @(posedge clk_pix or negedge reset_n) begin
    if (!reset_n) state <= ARM;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    load_masks = 1'b0;
    latch_hits = 1'b0;
    accumulate = 1'b0;
    case (state)
      ARM: begin
        if (frame) begin
          load_masks = 1'b1;
          state_nxt  = ACCUM;
        end
      end
      ACCUM: begin
        if (frame) begin
          load_masks = 1'b1;
          latch_hits = 1'b1;
        end else begin
          accumulate = ov_a & ov_b;
        end
      end
      default: state_nxt = ARM;
    endcase
  end

  // shadow_b_prev keeps the mask of the frame just closed for the score update.
  always_ff @(posedge clk_pix or negedge reset_n) begin
    if (!reset_n) begin
      shadow_a      <= '0;
      shadow_b      <= '0;
      shadow_b_prev <= '0;
      acc           <= '0;
      hit_vec       <= '0;
      any_hit       <= 1'b0;
      hit_valid     <= 1'b0;
    end else begin
      if (load_masks) begin
        shadow_a      <= group_a;
        shadow_b      <= group_b;
        shadow_b_prev <= shadow_b;
        acc           <= '0;
      end else if (accumulate) begin
        acc <= acc | (layer_drawing & (shadow_a | shadow_b));
      end
      hit_valid <= latch_hits;
      if (latch_hits) begin
        hit_vec <= acc;
        any_hit <= |acc;
      end
    end
  end

  assign b_hits = hit_vec & shadow_b_prev;
  assign b_cnt  = popcount(MAX_LAYERS'(b_hits));

  // Clear takes effect before the add so a coincident update starts from zero.
  always_comb begin
    score_base = score_clr ? '0 : SUM_W'(score);
    score_sum  = score_base + (hit_valid ? SUM_W'(b_cnt) : '0);
    score_nxt  = (score_sum > SCORE_MAX) ? SCORE_MAX[SCORE_W-1:0] : score_sum[SCORE_W-1:0];
  end

  always_ff @(posedge clk_pix or negedge reset_n) begin
    if (!reset_n) score <= '0;
    else          score <= score_nxt;
  end

  layer_priority_mux #(
    .LAYERS    (LAYERS),
    .COLR_BITS (COLR_BITS)
  ) u_mux (
    .drawing  (layer_drawing),
    .pixels   (layer_pixels),
    .colr     (mux_colr),
    .any_draw (mux_any)
  );

  always_comb begin
    pix_nxt = mux_any ? mux_colr : BG_COLR;
    if (HL_EN && ov_a && ov_b) pix_nxt = HIGHLIGHT_COLR;
    if (!de)                   pix_nxt = '0;
  end

  always_ff @(posedge clk_pix or negedge reset_n) begin
    if (!reset_n) begin
      pix_out <= '0;
      de_out  <= 1'b0;
    end else begin
      pix_out <= pix_nxt;
      de_out  <= de;
    end
  end

endmodule
